// File: rtl/bcp_run_ctrl.sv
// bcp_run_ctrl: load / init / run / drain sequencer in front of the BCP lookup top level.
// Optional feature macro BCP_RUN_TIMEOUT_EN adds a RUN-phase cycle timeout and a sticky timeout flag.
package bcp_run_ctrl_pkg;
  typedef logic [31:0] node_t;
  typedef logic [15:0] dummy_entry_t;
  typedef logic [15:0] lit_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_PTR = 3'd1,
    S_LOAD_CLA = 3'd2,
    S_NEXT_ENG = 3'd3,
    S_INIT_UC  = 3'd4,
    S_RUN      = 3'd5,
    S_DRAIN    = 3'd6,
    S_FINISH   = 3'd7
  } state_t;
endpackage

module bcp_run_ctrl
  import bcp_run_ctrl_pkg::*;
#(
  parameter int NUM_ENG      = 4,
  parameter int QUIET_CYCLES = 4,
  parameter int ENG_W        = 3
`ifdef BCP_RUN_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  node_t        host_node,
  input  logic         host_node_valid,
  input  logic         host_node_last,
  output logic         host_node_ready,
  input  dummy_entry_t host_ptr,
  input  logic         host_ptr_valid,
  output logic         host_ptr_ready,
  input  lit_t         host_lit,
  input  logic         host_lit_valid,
  input  logic         host_lit_last,
  output logic         host_lit_ready,
  output node_t        node_in,
  output logic         node_in_valid,
  output dummy_entry_t dummy_ptr,
  output logic         dummy_ptr_valid,
  output logic         change_eng,
  output lit_t         mem2uca,
  output logic         mem2uca_valid,
  output logic         mem2uca_done,
  output logic         halt,
  input  logic         conflict,
  input  logic         stall,
  input  logic         mstack_empty,
  input  lit_t         mstack_lit,
  output logic         mstack_pop,
  output lit_t         res_lit,
  output logic         res_valid,
  output logic         busy,
  output logic         done,
  output logic         sat,
  output logic         unsat,
`ifdef BCP_RUN_TIMEOUT_EN
  output logic         timeout,
`endif
  output state_t       state_dbg,
  output logic [ENG_W-1:0] eng_cnt_dbg
);

  localparam int QW = $clog2(QUIET_CYCLES) + 1;
  localparam logic [QW-1:0] QMAX = QW'(QUIET_CYCLES - 1);

  // Host handshakes: a beat transfers on a rising edge where valid & ready are both 1.
  // Readies depend only on state; the downstream top never back-pressures.
  state_t           state, next_state;
  logic [ENG_W-1:0] eng_cnt;
  logic [QW-1:0]    quiet_cnt;

`ifdef BCP_RUN_TIMEOUT_EN
  logic [15:0] run_cyc;
  logic        timeout_hit;
  assign timeout_hit = (run_cyc == 16'(TIMEOUT_CYC - 1));
`endif

  assign state_dbg   = state;
  assign eng_cnt_dbg = eng_cnt;

  always_comb begin
    next_state      = state;
    host_ptr_ready  = 1'b0;
    host_node_ready = 1'b0;
    host_lit_ready  = 1'b0;
    halt            = 1'b1;
    mstack_pop      = 1'b0;
    res_valid       = 1'b0;
    res_lit         = '0;
    done            = 1'b0;
    busy            = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) next_state = S_LOAD_PTR;
      end
      S_LOAD_PTR: begin
        host_ptr_ready = 1'b1;
        if (host_ptr_valid) next_state = S_LOAD_CLA;
      end
      S_LOAD_CLA: begin
        host_node_ready = 1'b1;
        if (host_node_valid && host_node_last) next_state = S_NEXT_ENG;
      end
      S_NEXT_ENG: begin
        if (eng_cnt == ENG_W'(NUM_ENG - 1)) next_state = S_INIT_UC;
        else                                next_state = S_LOAD_PTR;
      end
      S_INIT_UC: begin
        // Stay one extra cycle so halt only drops after mem2uca_done is seen.
        host_lit_ready = !mem2uca_done;
        if (mem2uca_done) next_state = S_RUN;
      end
      S_RUN: begin
        halt = 1'b0;
        if (conflict) next_state = S_FINISH;
`ifdef BCP_RUN_TIMEOUT_EN
        else if (timeout_hit) next_state = S_FINISH;
`endif
        else if (stall && quiet_cnt == QMAX) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        mstack_pop = !mstack_empty;
        res_valid  = !mstack_empty;
        res_lit    = mstack_lit;
        if (mstack_empty) next_state = S_FINISH;
      end
      S_FINISH: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      eng_cnt         <= '0;
      quiet_cnt       <= '0;
      node_in         <= '0;
      node_in_valid   <= 1'b0;
      dummy_ptr       <= '0;
      dummy_ptr_valid <= 1'b0;
      mem2uca         <= '0;
      mem2uca_valid   <= 1'b0;
      mem2uca_done    <= 1'b0;
      change_eng      <= 1'b0;
      sat             <= 1'b0;
      unsat           <= 1'b0;
    end else begin
      state           <= next_state;
      node_in         <= host_node;
      node_in_valid   <= host_node_valid && host_node_ready;
      dummy_ptr       <= host_ptr;
      dummy_ptr_valid <= host_ptr_valid && host_ptr_ready;
      mem2uca         <= host_lit;
      mem2uca_valid   <= host_lit_valid && host_lit_ready;
      mem2uca_done    <= host_lit_valid && host_lit_ready && host_lit_last;
      // Registered so the pulse trails the last node's forwarded valid by one cycle.
      change_eng      <= (state == S_NEXT_ENG);

      if (state == S_IDLE && start)   eng_cnt <= '0;
      else if (state == S_NEXT_ENG)   eng_cnt <= eng_cnt + ENG_W'(1);

      if (state != S_RUN || conflict || !stall) quiet_cnt <= '0;
      else if (quiet_cnt != QMAX)               quiet_cnt <= quiet_cnt + QW'(1);

      if (state == S_IDLE && start) begin
        sat   <= 1'b0;
        unsat <= 1'b0;
      end else begin
        if (state == S_RUN && conflict)       unsat <= 1'b1;
        if (state == S_DRAIN && mstack_empty) sat   <= 1'b1;
      end
    end
  end

`ifdef BCP_RUN_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cyc <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == S_RUN) run_cyc <= run_cyc + 16'd1;
      else                run_cyc <= '0;
      if (state == S_IDLE && start)                      timeout <= 1'b0;
      else if (state == S_RUN && timeout_hit && !conflict) timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bcp_run_ctrl.sv
// Bench for bcp_run_ctrl: table-driven run scenarios, hand sequences and randomized full transactions.
module tb_bcp_run_ctrl;
  import bcp_run_ctrl_pkg::*;

  localparam int NUM_ENG      = 4;
  localparam int QUIET_CYCLES = 4;
  localparam int ENG_W        = 3;

  logic         clk, rst_n, start;
  node_t        host_node;
  logic         host_node_valid, host_node_last, host_node_ready;
  dummy_entry_t host_ptr;
  logic         host_ptr_valid, host_ptr_ready;
  lit_t         host_lit;
  logic         host_lit_valid, host_lit_last, host_lit_ready;
  node_t        node_in;
  logic         node_in_valid;
  dummy_entry_t dummy_ptr;
  logic         dummy_ptr_valid, change_eng;
  lit_t         mem2uca;
  logic         mem2uca_valid, mem2uca_done, halt;
  logic         conflict, stall, mstack_empty, mstack_pop;
  lit_t         mstack_lit, res_lit;
  logic         res_valid, busy, done, sat, unsat;
`ifdef BCP_RUN_TIMEOUT_EN
  logic         timeout;
`endif
  state_t       state_dbg;
  logic [ENG_W-1:0] eng_cnt_dbg;

  bcp_run_ctrl #(.NUM_ENG(NUM_ENG), .QUIET_CYCLES(QUIET_CYCLES), .ENG_W(ENG_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .host_node(host_node), .host_node_valid(host_node_valid), .host_node_last(host_node_last),
    .host_node_ready(host_node_ready),
    .host_ptr(host_ptr), .host_ptr_valid(host_ptr_valid), .host_ptr_ready(host_ptr_ready),
    .host_lit(host_lit), .host_lit_valid(host_lit_valid), .host_lit_last(host_lit_last),
    .host_lit_ready(host_lit_ready),
    .node_in(node_in), .node_in_valid(node_in_valid),
    .dummy_ptr(dummy_ptr), .dummy_ptr_valid(dummy_ptr_valid), .change_eng(change_eng),
    .mem2uca(mem2uca), .mem2uca_valid(mem2uca_valid), .mem2uca_done(mem2uca_done),
    .halt(halt), .conflict(conflict), .stall(stall),
    .mstack_empty(mstack_empty), .mstack_lit(mstack_lit), .mstack_pop(mstack_pop),
    .res_lit(res_lit), .res_valid(res_valid), .busy(busy), .done(done),
    .sat(sat), .unsat(unsat),
`ifdef BCP_RUN_TIMEOUT_EN
    .timeout(timeout),
`endif
    .state_dbg(state_dbg), .eng_cnt_dbg(eng_cnt_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0, n_err = 0;
  node_t        exp_node_q[$];
  bit           exp_nlast_q[$];
  dummy_entry_t exp_ptr_q[$];
  lit_t         exp_lit_q[$];
  bit           exp_llast_q[$];
  lit_t         exp_res_q[$];
  lit_t         stack_q[$];
  lit_t         stk_init[$];
  int n_change, n_node_fwd, n_pop, n_done, n_res;
  int last_fwd_cyc = -10, uc_done_cyc = -10;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h req=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Bench-side model of the mstack: the top entry is visible until popped.
  always @(posedge clk) begin
    if (mstack_pop && stack_q.size() > 0) void'(stack_q.pop_front());
    #1;
    mstack_empty = (stack_q.size() == 0);
    mstack_lit   = (stack_q.size() == 0) ? lit_t'(0) : stack_q[0];
  end

  // Output monitor: compares every forwarded beat against the expected queues.
  always @(negedge clk) begin
    if (node_in_valid) begin
      n_node_fwd++;
      if (exp_node_q.size() == 0) chk("node_unexpected", 1, 0);
      else begin
        chk("node_in", node_in, exp_node_q.pop_front());
        if (exp_nlast_q.pop_front()) last_fwd_cyc = cyc;
      end
    end
    if (dummy_ptr_valid) begin
      if (exp_ptr_q.size() == 0) chk("ptr_unexpected", 1, 0);
      else chk("dummy_ptr", dummy_ptr, exp_ptr_q.pop_front());
    end
    if (change_eng) begin
      n_change++;
      chk("change_eng_timing", cyc, last_fwd_cyc + 1);
    end
    if (mem2uca_valid) begin
      if (exp_lit_q.size() == 0) chk("lit_unexpected", 1, 0);
      else begin
        chk("mem2uca", mem2uca, exp_lit_q.pop_front());
        chk("mem2uca_done", mem2uca_done, exp_llast_q.pop_front());
      end
    end
    if (mem2uca_done) uc_done_cyc = cyc;
    if (res_valid) begin
      n_res++;
      if (exp_res_q.size() == 0) chk("res_unexpected", 1, 0);
      else chk("res_lit", res_lit, exp_res_q.pop_front());
    end
    if (mstack_pop) n_pop++;
    if (done) n_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_ptr(input dummy_entry_t v);
    int w = 0;
    host_ptr = v; host_ptr_valid = 1'b1; exp_ptr_q.push_back(v);
    @(negedge clk);
    while (!host_ptr_ready && w < 50) begin @(negedge clk); w++; end
    if (!host_ptr_ready) chk("ptr_ready_timeout", 0, 1);
    @(posedge clk); #1;
    host_ptr_valid = 1'b0;
  endtask

  task automatic send_node(input node_t v, input bit last);
    int w = 0;
    host_node = v; host_node_valid = 1'b1; host_node_last = last;
    exp_node_q.push_back(v); exp_nlast_q.push_back(last);
    @(negedge clk);
    while (!host_node_ready && w < 50) begin @(negedge clk); w++; end
    if (!host_node_ready) chk("node_ready_timeout", 0, 1);
    @(posedge clk); #1;
    host_node_valid = 1'b0; host_node_last = 1'b0;
  endtask

  task automatic send_lit(input lit_t v, input bit last);
    int w = 0;
    host_lit = v; host_lit_valid = 1'b1; host_lit_last = last;
    exp_lit_q.push_back(v); exp_llast_q.push_back(last);
    @(negedge clk);
    while (!host_lit_ready && w < 50) begin @(negedge clk); w++; end
    if (!host_lit_ready) chk("lit_ready_timeout", 0, 1);
    @(posedge clk); #1;
    host_lit_valid = 1'b0; host_lit_last = 1'b0;
  endtask

  // Reference: the run ends at the first conflict (unsat), or once the most recent
  // QUIET_CYCLES samples were all stalls without conflict (drain, sat).
  function automatic void model_run(input logic [15:0] st, input logic [15:0] cf,
                                    output int len, output bit is_unsat);
    len = 16; is_unsat = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bit quiet;
      if (cf[k]) begin len = k + 1; is_unsat = 1'b1; return; end
      quiet = (k >= QUIET_CYCLES - 1);
      for (int j = 0; j < QUIET_CYCLES; j++) if (k - j < 0 || !st[k - j]) quiet = 1'b0;
      if (quiet) begin len = k + 1; return; end
    end
  endfunction

  // One full start -> load -> init -> run -> drain/finish transaction.
  task automatic run_txn(input int npe, input int nlit, input logic [15:0] st,
                         input logic [15:0] cf, input int exp_len, input bit exp_unsat);
    int k = 0, w = 0;
    n_change = 0; n_node_fwd = 0; n_pop = 0; n_done = 0; n_res = 0;
    stack_q = stk_init;
    exp_res_q.delete();
    if (!exp_unsat) foreach (stk_init[i]) exp_res_q.push_back(stk_init[i]);
    conflict = 1'b1; stall = 1'b1;  // engines are halted: these must be ignored
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int e = 0; e < NUM_ENG; e++) begin
      send_ptr(dummy_entry_t'($urandom()));
      if (e == 0) begin start = 1'b1; @(posedge clk); #1 start = 1'b0; end
      for (int j = 0; j < npe; j++) send_node(node_t'($urandom()), j == npe - 1);
    end
    repeat (2) @(posedge clk); #1;
    chk("change_eng_count", n_change, NUM_ENG);
    chk("node_fwd_count", n_node_fwd, NUM_ENG * npe);
    chk("state_after_load", state_dbg, S_INIT_UC);
    chk("halt_in_init", halt, 1);
    for (int i = 0; i < nlit; i++) send_lit(lit_t'($urandom_range(1, 1000)), i == nlit - 1);
    @(negedge clk);
    while (halt && w < 20) begin @(negedge clk); w++; end
    if (halt) chk("run_entry_timeout", 0, 1);
    else chk("halt_drop", cyc, uc_done_cyc + 1);
    while (!halt && k < 16) begin
      stall = st[k]; conflict = cf[k]; k++;
      @(negedge clk);
    end
    stall = 1'b0; conflict = 1'b0;
    chk("run_len", k, exp_len);
    w = 0;
    while (n_done == 0 && w < 40) begin @(posedge clk); w++; end
    @(posedge clk); #1;
    chk("done_pulses", n_done, 1);
    chk("sat", sat, !exp_unsat);
    chk("unsat", unsat, exp_unsat);
    chk("halt_after", halt, 1);
    chk("state_after", state_dbg, S_IDLE);
    chk("res_count", n_res, exp_unsat ? 0 : stk_init.size());
    if (exp_unsat) chk("no_pop_on_conflict", n_pop, 0);
    chk("queues_drained", exp_node_q.size() + exp_ptr_q.size() + exp_lit_q.size() + exp_res_q.size(), 0);
  endtask

  typedef struct {
    logic [15:0] st;
    logic [15:0] cf;
    int          exp_len;
    bit          exp_unsat;
  } run_vec_t;

  // ---------------- main sequence ----------------
  initial begin
    run_vec_t tbl[6];
    int  m_len;
    bit  m_unsat;
    logic [15:0] rst_pat, rcf;

    start = 0; host_node = '0; host_node_valid = 0; host_node_last = 0;
    host_ptr = '0; host_ptr_valid = 0; host_lit = '0; host_lit_valid = 0; host_lit_last = 0;
    conflict = 0; stall = 0; mstack_empty = 1; mstack_lit = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;

    // reset state
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_halt", halt, 1);
    chk("rst_outputs", {busy, done, sat, unsat, node_in_valid, dummy_ptr_valid, change_eng,
                        mem2uca_valid, mem2uca_done, mstack_pop, res_valid}, 0);
    chk("rst_readies", {host_node_ready, host_ptr_ready, host_lit_ready}, 0);
    chk("rst_eng_cnt", eng_cnt_dbg, 0);

    // host valids while idle are ignored
    host_node_valid = 1'b1; host_ptr_valid = 1'b1; host_lit_valid = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_readies", {host_node_ready, host_ptr_ready, host_lit_ready}, 0);
    chk("idle_state", state_dbg, S_IDLE);
    host_node_valid = 1'b0; host_ptr_valid = 1'b0; host_lit_valid = 1'b0;

    tbl[0] = '{16'hFFFF, 16'h0000, 4, 1'b0};  // stall held high
    tbl[1] = '{16'h007B, 16'h0000, 7, 1'b0};  // 1,1,0,1,1,1,1
    tbl[2] = '{16'hFFFF, 16'h0008, 4, 1'b1};  // conflict as quiet count reaches 3
    tbl[3] = '{16'h0000, 16'h0001, 1, 1'b1};  // conflict in first RUN cycle
    tbl[4] = '{16'h00F7, 16'h0000, 8, 1'b0};  // 1,1,1,0,1,1,1,1
    tbl[5] = '{16'h0007, 16'h0020, 6, 1'b1};  // broken quiet run, then conflict

    for (int i = 0; i < 6; i++) begin
      stk_init.delete();
      if (i == 0) begin stk_init.push_back(16'd5); stk_init.push_back(16'd9); stk_init.push_back(16'd12); end
      else if (i != 4) for (int j = 0; j < $urandom_range(1, 4); j++) stk_init.push_back(lit_t'($urandom_range(1, 500)));
      if (i == 0) run_txn(3, 2, tbl[i].st, tbl[i].cf, tbl[i].exp_len, tbl[i].exp_unsat);
      else run_txn($urandom_range(1, 4), $urandom_range(1, 3), tbl[i].st, tbl[i].cf,
                   tbl[i].exp_len, tbl[i].exp_unsat);
    end

    // reset while loading clauses, then a clean reload
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    send_ptr(16'h0A0A);
    send_node(32'h1234_5678, 1'b0);
    chk("pre_rst_state", state_dbg, S_LOAD_CLA);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("mid_rst_state", state_dbg, S_IDLE);
    chk("mid_rst_halt", halt, 1);
    chk("mid_rst_node_ready", host_node_ready, 0);
    chk("mid_rst_eng_cnt", eng_cnt_dbg, 0);
    exp_node_q.delete(); exp_nlast_q.delete(); exp_ptr_q.delete();
    stk_init.delete(); stk_init.push_back(16'd77);
    run_txn(2, 1, 16'hFFFF, 16'h0000, 4, 1'b0);

    // randomized transactions against the reference model
    for (int t = 0; t < 10; t++) begin
      rst_pat = {4'hF, 12'($urandom())};
      rcf = '0;
      for (int b = 0; b < 12; b++) if ($urandom_range(0, 19) == 0) rcf[b] = 1'b1;
      model_run(rst_pat, rcf, m_len, m_unsat);
      stk_init.delete();
      for (int j = 0; j < $urandom_range(0, 5); j++) stk_init.push_back(lit_t'($urandom()));
      run_txn($urandom_range(1, 4), $urandom_range(1, 4), rst_pat, rcf, m_len, m_unsat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcp_run_ctrl.md
Name: bcp_run_ctrl

Overview:
- Sequencer in front of the lookup top level; drives its load, init, run and drain phases.
- Streams clause nodes and dummy pointers into the L-buffer one engine at a time (pulsing change_eng), then injects initial unit literals.
- Releases halt, detects quiescence or conflict, then drains the mstack into a result stream and reports SAT/CONFLICT.

Parameters:
- NUM_ENG, 4: engines to load; must equal `NUM_ENGINE.
- QUIET_CYCLES, 4: consecutive cycles with stall=1 and conflict=0 required to declare quiescence.
- ENG_W, 3: engine counter width, at least clog2(NUM_ENG)+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- host_node  in  node_t  clause node from host.
- host_node_valid  in  1  node valid.
- host_node_last  in  1  last node for the current engine.
- host_node_ready  out  1  node accepted when valid&ready.
- host_ptr  in  dummy_entry_t  dummy pointer entry.
- host_ptr_valid  in  1  pointer valid.
- host_ptr_ready  out  1  pointer accepted when valid&ready.
- host_lit  in  lit_t  initial unit literal.
- host_lit_valid  in  1  literal valid.
- host_lit_last  in  1  final initial literal.
- host_lit_ready  out  1  literal accepted.
- node_in  out  node_t  to top.node_in.
- node_in_valid  out  1  to top.
- dummy_ptr  out  dummy_entry_t  to top.
- dummy_ptr_valid  out  1  to top.
- change_eng  out  1  to top; one-cycle pulse.
- mem2uca  out  lit_t  to top.
- mem2uca_valid  out  1  to top.
- mem2uca_done  out  1  to top.
- halt  out  1  to top.halt.
- conflict  in  1  from top.
- stall  in  1  from top.
- mstack_empty  in  1  from top.
- mstack_lit  in  lit_t  from top.
- mstack_pop  out  1  to top.
- res_lit  out  lit_t  drained literal.
- res_valid  out  1  res_lit valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at finish.
- sat  out  1  sticky result, cleared by start.
- unsat  out  1  sticky result, cleared by start.

Behaviour:
- Reset: state=IDLE, eng_cnt=0, quiet_cnt=0. All outputs 0 except halt=1.
- Forwarding: registered, one-cycle latency. node_in/node_in_valid = previous-cycle host_node & accepted handshake; dummy_ptr and mem2uca likewise. No back-pressure from top; readies depend only on state.
- IDLE: halt=1. On start, clear sat/unsat and go to LOAD_PTR.
- LOAD_PTR: host_ptr_ready=1. Accept exactly one pointer, then go to LOAD_CLA.
- LOAD_CLA: host_node_ready=1. On an accepted node with last=1, go to NEXT_ENG.
- NEXT_ENG: change_eng=1 for exactly one cycle, eng_cnt++. If eng_cnt+1==NUM_ENG go to INIT_UC, else to LOAD_PTR. The pulse comes the cycle after the last node's forwarded valid.
- INIT_UC: host_lit_ready=1. Each accepted literal gives mem2uca_valid the next cycle. mem2uca_done is asserted with the last literal's valid. Then go to RUN.
- Halt rule: halt=1 in all states except RUN.
- RUN: halt=0.
  - conflict=1 in any RUN cycle → FINISH with unsat=1. Conflict has priority over quiescence in the same cycle.
  - Otherwise stall=1 increments quiet_cnt; stall=0 clears it.
  - quiet_cnt==QUIET_CYCLES-1 with stall=1 → DRAIN.
  - quiet_cnt saturates and does not wrap.
- DRAIN:
  - mstack_pop=!mstack_empty.
  - res_lit=mstack_lit and res_valid=1 in the same cycle as the pop (combinational peek of stack top).
  - mstack_empty=1 → FINISH with sat=1.
  - Draining an empty stack (zero implied literals) is legal; it reaches FINISH in 1 cycle.
- FINISH: done=1 for one cycle → IDLE.
- start outside IDLE is ignored.
- Host valid outside the matching state is ignored; ready stays 0.
- A conflict during LOAD/INIT states is ignored (engines halted).
- Reset mid-operation: synchronous return to reset values on the next edge; partially loaded state in downstream blocks is the reset's responsibility.

Optional Feature:
- Macro: BCP_RUN_TIMEOUT_EN.
- Enabled:
  - Adds parameter TIMEOUT_CYC, default 4096, and output timeout (1 bit, sticky, cleared by start).
  - A 16-bit counter increments each RUN cycle.
  - Reaching TIMEOUT_CYC → FINISH with timeout=1, sat=0, unsat=0, no drain.
  - Conflict in the same cycle wins and sets unsat.
- Disabled: no counter and no port; RUN waits indefinitely.

Test Plan:
- NUM_ENG=4, 3 nodes per engine with last on the 3rd, 1 pointer each → 12 node_in_valid pulses, exactly 4 change_eng pulses each one cycle after the engine's last node, then state INIT_UC.
- 2 initial literals (last on 2nd) → mem2uca_valid on 2 cycles; mem2uca_done coincides with the 2nd; halt drops the following cycle.
- RUN with stall held 1 and conflict 0 → DRAIN after exactly 4 cycles. With stall toggling 1,1,0,1,1,1,1 → DRAIN only after the final 4-run.
- DRAIN with mstack holding literals 5, 9, 12 → 3 res_valid beats in pop order, then done pulse, sat=1, halt=1.
- conflict=1 on the same cycle quiet_cnt reaches 3 → unsat=1, sat=0, no mstack_pop ever asserted.
- Reset asserted in LOAD_CLA for 1 cycle → next cycle IDLE, halt=1, host_node_ready=0, eng_cnt=0. A new start reloads cleanly.
